ycbcr422_to_rgb: RTL and testbench

- Inverse colour-space converter that takes a 4:2:2 YCbCr pixel stream and produces 4:4:4 RGB at 12 bits per channel.
- Sits at the output side of the video pipeline, opposite the forward RGB-to-YCbCr converter, ahead of the HDMI/parallel output stage.
- Pairs luma samples with their shared chroma samples, replicates the chroma to both pixels, and runs a 3-stage fixed-point matrix with rounding and clamping.

---
 rtl/ycbcr422_to_rgb.sv | 191 +++++++++++++++++++
 tb/tb_ycbcr422_to_rgb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr422_to_rgb.sv
// 4:2:2 YCbCr to 4:4:4 RGB converter. Pixel0 is on dout two edges after its Cr beat, and pixel1 one edge later.
// There is no backpressure: every din_valid beat is accepted. An incomplete pair is dropped with an orphan_err pulse.
module ycbcr422_to_rgb #(
    parameter int DW    = 12,
    parameter int C_OFS = 2048,
    parameter int K_RCR = 5743,
    parameter int K_GCB = 1410,
    parameter int K_GCR = 2925,
    parameter int K_BCB = 7258
) (
    input  logic          icsc_clk,
    input  logic          icsc_rst,
    input  logic [DW-1:0] din_y,
    input  logic [DW-1:0] din_c,
    input  logic          din_valid,
    input  logic          din_line_start,
    output logic [DW-1:0] dout0,
    output logic [DW-1:0] dout1,
    output logic [DW-1:0] dout2,
    output logic          dout_valid,
    output logic          dout_line_start,
    output logic          orphan_err
);

    localparam int KW = 15;
    localparam int PW = DW + 1 + KW;
    localparam int AW = PW + 2;

    localparam logic signed [KW-1:0] C_KRCR  = KW'(K_RCR);
    localparam logic signed [KW-1:0] C_KGCB  = KW'(K_GCB);
    localparam logic signed [KW-1:0] C_KGCR  = KW'(K_GCR);
    localparam logic signed [KW-1:0] C_KBCB  = KW'(K_BCB);
    localparam logic signed [DW:0]   C_OFS_S = (DW+1)'(C_OFS);
    localparam logic signed [AW-1:0] C_RND   = AW'(2048);
    localparam logic signed [AW-1:0] C_MAX   = AW'((2**DW) - 1);

    typedef enum logic {ST_CB = 1'b0, ST_CR = 1'b1} phase_t;

    function automatic logic signed [DW:0] f_center(input logic [DW-1:0] c);
        return $signed({1'b0, c}) - C_OFS_S;
    endfunction

    function automatic logic [DW-1:0] f_clamp(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] sh;
        logic [DW-1:0]        res;
        sh = acc >>> 12;
        if (sh[AW-1])
            res = '0;
        else if (sh > C_MAX)
            res = '1;
        else
            res = sh[DW-1:0];
        return res;
    endfunction

    phase_t r_state, w_state_nxt;
    logic   w_store_cb, w_launch0, w_orphan;

    logic [DW-1:0] r_y0, r_cb, r_y1, r_cr;
    logic          r_ls, r_launch1, r_orphan;

    logic                 r_s1_vld, r_s1_ls;
    logic [DW-1:0]        r_s1_y;
    logic signed [DW:0]   r_s1_cb, r_s1_cr;

    logic                 r_s2_vld, r_s2_ls;
    logic [DW-1:0]        r_s2_y;
    logic signed [PW-1:0] r_s2_rcr, r_s2_gcb, r_s2_gcr, r_s2_bcb;

    logic [DW-1:0] r_dout0, r_dout1, r_dout2;
    logic          r_dout_vld, r_dout_ls;

    logic signed [AW-1:0] w_ybase, w_acc_r, w_acc_g, w_acc_b;

    always_ff @(posedge icsc_clk) begin
        if (icsc_rst)
            r_state <= ST_CB;
        else
            r_state <= w_state_nxt;
    end

    // A line_start seen while waiting for Cr abandons the stored Cb half and restarts the pair.
    always_comb begin
        w_state_nxt = r_state;
        w_store_cb  = 1'b0;
        w_launch0   = 1'b0;
        w_orphan    = 1'b0;
        if (din_valid) begin
            case (r_state)
                ST_CB: begin
                    w_store_cb  = 1'b1;
                    w_state_nxt = ST_CR;
                end
                ST_CR: begin
                    if (din_line_start) begin
                        w_store_cb = 1'b1;
                        w_orphan   = 1'b1;
                    end else begin
                        w_launch0   = 1'b1;
                        w_state_nxt = ST_CB;
                    end
                end
                default: w_state_nxt = ST_CB;
            endcase
        end
    end

    assign w_ybase = $signed({{(AW-DW-12){1'b0}}, r_s2_y, 12'd0});
    assign w_acc_r = w_ybase + AW'(r_s2_rcr) + C_RND;
    assign w_acc_g = w_ybase - AW'(r_s2_gcb) - AW'(r_s2_gcr) + C_RND;
    assign w_acc_b = w_ybase + AW'(r_s2_bcb) + C_RND;

    always_ff @(posedge icsc_clk) begin
        if (icsc_rst) begin
            r_y0       <= '0;
            r_cb       <= '0;
            r_ls       <= 1'b0;
            r_y1       <= '0;
            r_cr       <= '0;
            r_launch1  <= 1'b0;
            r_orphan   <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_ls    <= 1'b0;
            r_s1_y     <= '0;
            r_s1_cb    <= '0;
            r_s1_cr    <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_ls    <= 1'b0;
            r_s2_y     <= '0;
            r_s2_rcr   <= '0;
            r_s2_gcb   <= '0;
            r_s2_gcr   <= '0;
            r_s2_bcb   <= '0;
            r_dout0    <= '0;
            r_dout1    <= '0;
            r_dout2    <= '0;
            r_dout_vld <= 1'b0;
            r_dout_ls  <= 1'b0;
        end else begin
            if (w_store_cb) begin
                r_y0 <= din_y;
                r_cb <= din_c;
                r_ls <= din_line_start;
            end
            if (w_launch0) begin
                r_y1 <= din_y;
                r_cr <= din_c;
            end
            r_launch1 <= w_launch0;
            r_orphan  <= w_orphan;

            // Pixel1 can never collide with pixel0: the beat after a Cr beat is always a Cb beat.
            r_s1_vld <= w_launch0 | r_launch1;
            if (w_launch0) begin
                r_s1_y  <= r_y0;
                r_s1_cb <= f_center(r_cb);
                r_s1_cr <= f_center(din_c);
                r_s1_ls <= r_ls;
            end else if (r_launch1) begin
                r_s1_y  <= r_y1;
                r_s1_cb <= f_center(r_cb);
                r_s1_cr <= f_center(r_cr);
                r_s1_ls <= 1'b0;
            end

            r_s2_vld <= r_s1_vld;
            r_s2_ls  <= r_s1_ls;
            r_s2_y   <= r_s1_y;
            r_s2_rcr <= PW'(C_KRCR) * PW'(r_s1_cr);
            r_s2_gcb <= PW'(C_KGCB) * PW'(r_s1_cb);
            r_s2_gcr <= PW'(C_KGCR) * PW'(r_s1_cr);
            r_s2_bcb <= PW'(C_KBCB) * PW'(r_s1_cb);

            r_dout_vld <= r_s2_vld;
            r_dout_ls  <= r_s2_vld & r_s2_ls;
            if (r_s2_vld) begin
                r_dout0 <= f_clamp(w_acc_r);
                r_dout1 <= f_clamp(w_acc_g);
                r_dout2 <= f_clamp(w_acc_b);
            end
        end
    end

    assign dout0           = r_dout0;
    assign dout1           = r_dout1;
    assign dout2           = r_dout2;
    assign dout_valid      = r_dout_vld;
    assign dout_line_start = r_dout_ls;
    assign orphan_err      = r_orphan;

endmodule

// File: tb/tb_ycbcr422_to_rgb.sv
// Directed bench for ycbcr422_to_rgb: an integer model fills a scoreboard and a negedge monitor drains it.
module tb_ycbcr422_to_rgb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] din_y = '0;
    logic [11:0] din_c = '0;
    logic        din_valid = 1'b0;
    logic        din_ls = 1'b0;
    logic [11:0] dout0, dout1, dout2;
    logic        dout_valid, dout_line_start, orphan_err;

    ycbcr422_to_rgb dut (
        .icsc_clk        (clk),
        .icsc_rst        (rst),
        .din_y           (din_y),
        .din_c           (din_c),
        .din_valid       (din_valid),
        .din_line_start  (din_ls),
        .dout0           (dout0),
        .dout1           (dout1),
        .dout2           (dout2),
        .dout_valid      (dout_valid),
        .dout_line_start (dout_line_start),
        .orphan_err      (orphan_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int r;
        int g;
        int b;
        bit ls;
        int edge_n;
    } px_t;

    px_t sb[$];
    px_t mon_e;
    int  total = 0;
    int  bad = 0;
    int  orph_edge = -1;
    bit  mon_en = 1'b0;
    bit  m_cr = 1'b0;
    int  m_y0 = 0;
    int  m_cb = 0;
    bit  m_ls = 1'b0;

    function automatic int clamp12(input int a);
        int s;
        s = a >>> 12;
        if (s < 0) s = 0;
        if (s > 4095) s = 4095;
        return s;
    endfunction

    function automatic px_t mk(input int y, input int cb, input int cr, input bit ls, input int e);
        px_t p;
        int  cbs, crs;
        cbs = cb - 2048;
        crs = cr - 2048;
        p.r = clamp12(y * 4096 + 5743 * crs + 2048);
        p.g = clamp12(y * 4096 - 1410 * cbs - 2925 * crs + 2048);
        p.b = clamp12(y * 4096 + 7258 * cbs + 2048);
        p.ls = ls;
        p.edge_n = e;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("orphan_err", {31'd0, orphan_err}, (cyc == orph_edge) ? 32'd1 : 32'd0);
            if (dout_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_pixel", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("px_R", {20'd0, dout0}, mon_e.r);
                    chk("px_G", {20'd0, dout1}, mon_e.g);
                    chk("px_B", {20'd0, dout2}, mon_e.b);
                    chk("px_line_start", {31'd0, dout_line_start}, {31'd0, mon_e.ls});
                    chk("px_latency_edge", cyc, mon_e.edge_n);
                end
            end else begin
                chk("dout_valid_low", {31'd0, dout_valid}, 32'd0);
                chk("ls_without_valid", {31'd0, dout_line_start}, 32'd0);
            end
        end
    end

    task automatic beat(input int y, input int c, input bit ls);
        int n;
        @(negedge clk);
        n = cyc + 1;
        if (!m_cr || ls) begin
            if (m_cr) orph_edge = n;
            m_y0 = y;
            m_cb = c;
            m_ls = ls;
            m_cr = 1'b1;
        end else begin
            sb.push_back(mk(m_y0, m_cb, c, m_ls, n + 2));
            sb.push_back(mk(y, m_cb, c, 1'b0, n + 3));
            m_cr = 1'b0;
        end
        din_y = 12'(y);
        din_c = 12'(c);
        din_ls = ls;
        din_valid = 1'b1;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            din_valid = 1'b0;
            din_ls = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle(1);
        while (sb.size() != 0 && t < 30) begin
            idle(1);
            t++;
        end
        chk("drain_timeout", sb.size(), 32'd0);
        idle(1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dout0"}, {20'd0, dout0}, 32'd0);
        chk({tag, "_dout1"}, {20'd0, dout1}, 32'd0);
        chk({tag, "_dout2"}, {20'd0, dout2}, 32'd0);
        chk({tag, "_valid"}, {31'd0, dout_valid}, 32'd0);
        chk({tag, "_ls"}, {31'd0, dout_line_start}, 32'd0);
        chk({tag, "_orphan"}, {31'd0, orphan_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int y, cb, cr, g;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Neutral grey pair
        beat(2048, 2048, 1'b1);
        beat(2048, 2048, 1'b0);
        drain();

        // Clamp cases
        beat(0, 2048, 1'b1);
        beat(0, 4095, 1'b0);
        drain();
        beat(4095, 4095, 1'b1);
        beat(4095, 2048, 1'b0);
        drain();

        // Eight back-to-back beats forming one line
        for (int i = 0; i < 8; i++)
            beat(100 + i * 500, (i * 613 + 300) % 4096, i == 0);
        drain();

        // Same pair ungapped then with a 3-cycle gap before Cr
        beat(1000, 1500, 1'b1);
        beat(3000, 2600, 1'b0);
        drain();
        beat(1000, 1500, 1'b1);
        idle(3);
        beat(3000, 2600, 1'b0);
        drain();

        // Odd line: third beat orphaned by the next line_start
        beat(500, 1000, 1'b1);
        beat(600, 3000, 1'b0);
        beat(700, 1200, 1'b0);
        beat(800, 2200, 1'b1);
        beat(900, 2900, 1'b0);
        drain();

        // Reset between Cb and Cr beats
        beat(1234, 3000, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        din_ls = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_cr = 1'b0;
        check_zero("midpair_reset");
        idle(4);
        beat(2222, 1111, 1'b1);
        beat(3333, 3999, 1'b0);
        drain();

        // Random pairs with random gaps
        for (int i = 0; i < 6; i++) begin
            y  = $urandom_range(0, 4095);
            cb = $urandom_range(0, 4095);
            cr = $urandom_range(0, 4095);
            g  = $urandom_range(0, 2);
            beat(y, cb, i == 0);
            if (g != 0) idle(g);
            beat($urandom_range(0, 4095), cr, 1'b0);
        end
        drain();

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
